tlb_ctrl: RTL and testbench

- Sequencer in front of the shared set-associative TLB array (`cache`: address + PCID in, translated address + per-way hit vector out).
- Round-robin arbitrates two translation requesters (port 0 = instruction side, port 1 = data side) onto the single lookup port.
- On a miss, issues a page-walk request, writes the walk result into a victim way, then returns the translation.
- One translation in flight at a time.

---
 rtl/tlb_ctrl.sv | 146 ++++++++++++++
 tb/tb_tlb_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_ctrl.sv
// tlb_ctrl: round-robin sequencer between two translation requesters and a shared
// set-associative TLB array; on a miss it walks, fills a victim way and responds.
//  state     | meaning
//  IDLE      | arbitrate and accept one request
//  LOOKUP    | lookup address/PCID presented to the array
//  CHECK     | array result valid; hit -> RESP, miss -> WALK_REQ
//  WALK_REQ  | walk request held until the walker accepts
//  WALK_WAIT | waiting for the walk result
//  FILL      | one-cycle write of the walk result into the victim way
//  RESP      | one-cycle response pulse
module tlb_ctrl #(
  parameter int VA_W   = 64,
  parameter int PCID_W = 12,
  parameter int PG_OFF = 12,
  parameter int WAYS   = 8,
  parameter int WAY_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [VA_W-1:0]        req_vaddr0,
  input  logic [VA_W-1:0]        req_vaddr1,
  input  logic [PCID_W-1:0]      req_pcid0,
  input  logic [PCID_W-1:0]      req_pcid1,
  output logic                   resp_valid,
  output logic                   resp_id,
  output logic [VA_W-1:0]        resp_paddr,
  output logic                   resp_fault,
  output logic [VA_W-1:0]        lk_addr,
  output logic [PCID_W-1:0]      lk_pcid,
  input  logic [VA_W-1:0]        lk_paddr,
  input  logic [WAYS-1:0]        lk_hit,
  output logic                   walk_valid,
  input  logic                   walk_ready,
  output logic [VA_W-PG_OFF-1:0] walk_vpn,
  output logic [PCID_W-1:0]      walk_pcid,
  input  logic                   walk_done,
  input  logic [VA_W-PG_OFF-1:0] walk_ppn,
  input  logic                   walk_fault,
  output logic                   fill_en,
  output logic [WAY_W-1:0]       fill_way,
  output logic [VA_W-PG_OFF-1:0] fill_vpn,
  output logic [PCID_W-1:0]      fill_pcid,
  output logic [VA_W-PG_OFF-1:0] fill_ppn
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, WALK_REQ, WALK_WAIT, FILL, RESP
  } state_t;

  state_t                 state, state_d;
  logic                   gnt_id;
  logic                   ptr;
  logic [WAY_W-1:0]       victim;
  logic [VA_W-1:0]        vaddr_q;
  logic [PCID_W-1:0]      pcid_q;
  logic                   id_q;
  logic [VA_W-1:0]        paddr_q;
  logic                   fault_q;
  logic [VA_W-PG_OFF-1:0] ppn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    req_ready = 2'b00;
    gnt_id    = 1'b0;
    if (req_valid == 2'b10)      gnt_id = 1'b1;
    else if (req_valid == 2'b11) gnt_id = ptr;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready = gnt_id ? 2'b10 : 2'b01;
          state_d   = LOOKUP;
        end
      end
      LOOKUP:    state_d = CHECK;
      CHECK:     state_d = (|lk_hit) ? RESP : WALK_REQ;
      WALK_REQ:  if (walk_ready) state_d = WALK_WAIT;
      WALK_WAIT: if (walk_done) state_d = walk_fault ? RESP : FILL;
      FILL:      state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Latched request, result and victim pointer; all outputs below derive from these.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= 1'b0;
      victim  <= '0;
      vaddr_q <= '0;
      pcid_q  <= '0;
      id_q    <= 1'b0;
      paddr_q <= '0;
      fault_q <= 1'b0;
      ppn_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            id_q    <= gnt_id;
            vaddr_q <= gnt_id ? req_vaddr1 : req_vaddr0;
            pcid_q  <= gnt_id ? req_pcid1 : req_pcid0;
            fault_q <= 1'b0;
            if (&req_valid) ptr <= ~ptr;
          end
        end
        CHECK: if (|lk_hit) paddr_q <= lk_paddr;
        WALK_WAIT: begin
          if (walk_done) begin
            if (walk_fault) begin
              fault_q <= 1'b1;
              paddr_q <= '0;
            end else begin
              ppn_q   <= walk_ppn;
              paddr_q <= {walk_ppn, vaddr_q[PG_OFF-1:0]};
            end
          end
        end
        FILL: victim <= (victim == WAY_W'(WAYS-1)) ? '0 : victim + 1'b1;
        default: ;
      endcase
    end
  end

  assign lk_addr    = vaddr_q;
  assign lk_pcid    = pcid_q;
  assign walk_valid = (state == WALK_REQ);
  assign walk_vpn   = vaddr_q[VA_W-1:PG_OFF];
  assign walk_pcid  = pcid_q;
  assign fill_en    = (state == FILL);
  assign fill_way   = victim;
  assign fill_vpn   = vaddr_q[VA_W-1:PG_OFF];
  assign fill_pcid  = pcid_q;
  assign fill_ppn   = ppn_q;
  assign resp_valid = (state == RESP);
  assign resp_id    = id_q;
  assign resp_paddr = paddr_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl: timestamp-based transaction model plus directed test-plan scenarios
// and randomized traffic; the bench also plays the TLB array and the page walker.
module tb_tlb_ctrl;
  localparam int VA_W = 64, PCID_W = 12, PG_OFF = 12, WAYS = 8, WAY_W = 3;
  localparam int VPN_W = VA_W - PG_OFF;

  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] req_valid, req_ready;
  logic [VA_W-1:0] req_vaddr0, req_vaddr1, resp_paddr, lk_addr, lk_paddr;
  logic [PCID_W-1:0] req_pcid0, req_pcid1, lk_pcid, walk_pcid, fill_pcid;
  logic resp_valid, resp_id, resp_fault, walk_valid, walk_ready, walk_done, walk_fault, fill_en;
  logic [WAYS-1:0] lk_hit;
  logic [VPN_W-1:0] walk_vpn, walk_ppn, fill_vpn, fill_ppn;
  logic [WAY_W-1:0] fill_way;

  always #5 clk = ~clk;

  tlb_ctrl #(.VA_W(VA_W), .PCID_W(PCID_W), .PG_OFF(PG_OFF), .WAYS(WAYS), .WAY_W(WAY_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr0(req_vaddr0), .req_vaddr1(req_vaddr1), .req_pcid0(req_pcid0), .req_pcid1(req_pcid1),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_paddr(resp_paddr), .resp_fault(resp_fault),
    .lk_addr(lk_addr), .lk_pcid(lk_pcid), .lk_paddr(lk_paddr), .lk_hit(lk_hit),
    .walk_valid(walk_valid), .walk_ready(walk_ready), .walk_vpn(walk_vpn), .walk_pcid(walk_pcid),
    .walk_done(walk_done), .walk_ppn(walk_ppn), .walk_fault(walk_fault),
    .fill_en(fill_en), .fill_way(fill_way), .fill_vpn(fill_vpn), .fill_pcid(fill_pcid),
    .fill_ppn(fill_ppn));

  int n_checks = 0, n_err = 0, cyc = 0;

  // stimulus knobs: vmode 0 none, 1 port0, 2 port1, 3 both, 4 random
  int vmode = 0, txn_left = 0, hs_count = 0;
  logic fix_addr = 1'b0, force_done = 1'b0;
  logic [VA_W-1:0] fx_va0, fx_va1;
  logic [PCID_W-1:0] fx_pc0, fx_pc1;
  logic dir_en = 1'b0, dir_hit, dir_fault;
  logic [WAYS-1:0] dir_vec;
  logic [VA_W-1:0] dir_paddr;
  int dir_rdy, dir_lat;
  logic [VPN_W-1:0] dir_ppn;

  // model: arbitration pointer, victim way, and the current transaction's event timestamps
  logic ptr = 1'b0;
  int victim = 0;
  logic have = 1'b0;
  int hs, rdy_at, done_at, fill_at, resp_at;
  logic t_id, t_hit, t_fault;
  logic [VA_W-1:0] t_va, t_lkpa = '0, t_pa;
  logic [PCID_W-1:0] t_pc;
  logic [WAYS-1:0] t_vec;
  logic [VPN_W-1:0] t_ppn;

  // observations of the DUT, pinned against literals after directed scenarios
  int obs_hs_cyc, obs_resp_cyc, obs_walk_cnt = 0;
  logic [VA_W-1:0] obs_resp_pa;
  logic obs_resp_id, obs_resp_fault;
  logic [VPN_W-1:0] obs_walk_vpn, obs_fill_vpn, obs_fill_ppn;
  int fill_q[$], grant_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic busy();
    return have && cyc > hs && cyc <= resp_at;
  endfunction

  task automatic drive();
    logic in_win;
    case (vmode)
      0: req_valid = 2'b00;
      1: req_valid = 2'b01;
      2: req_valid = 2'b10;
      3: req_valid = 2'b11;
      default: req_valid = 2'($urandom_range(0, 3));
    endcase
    if (fix_addr) begin
      req_vaddr0 = fx_va0; req_vaddr1 = fx_va1; req_pcid0 = fx_pc0; req_pcid1 = fx_pc1;
    end else begin
      req_vaddr0 = {$urandom, $urandom}; req_vaddr1 = {$urandom, $urandom};
      req_pcid0 = 12'($urandom); req_pcid1 = 12'($urandom);
    end
    lk_hit   = (have && t_hit) ? t_vec : '0;
    lk_paddr = t_lkpa;
    in_win = have && !t_hit && cyc >= hs + 3 && cyc <= rdy_at;
    walk_ready = in_win ? (cyc == rdy_at) : 1'($urandom);
    if (have && !t_hit && cyc == done_at) begin
      walk_done = 1'b1; walk_ppn = t_ppn; walk_fault = t_fault;
    end else begin
      walk_done  = !busy() && (force_done || $urandom_range(0, 7) == 0);
      walk_ppn   = 52'({$urandom, $urandom});
      walk_fault = 1'($urandom);
    end
  endtask

  task automatic check();
    logic [1:0] er;
    logic ew, ef, erv;
    er = 2'b00;
    if (!busy())
      case (req_valid)
        2'b01: er = 2'b01;
        2'b10: er = 2'b10;
        2'b11: er = ptr ? 2'b10 : 2'b01;
        default: er = 2'b00;
      endcase
    chk("req_ready", 64'(req_ready), 64'(er));
    if ((req_ready & req_valid) != 2'b00) begin
      obs_hs_cyc = cyc;
      grant_q.push_back(int'(req_ready == 2'b10));
    end
    if (have && (cyc == hs + 1 || cyc == hs + 2)) begin
      chk("lk_addr", lk_addr, t_va);
      chk("lk_pcid", 64'(lk_pcid), 64'(t_pc));
    end
    if (walk_valid) obs_walk_cnt++;
    ew = have && !t_hit && cyc >= hs + 3 && cyc <= rdy_at;
    chk("walk_valid", 64'(walk_valid), 64'(ew));
    if (ew) begin
      chk("walk_vpn", 64'(walk_vpn), 64'(t_va[VA_W-1:PG_OFF]));
      chk("walk_pcid", 64'(walk_pcid), 64'(t_pc));
      obs_walk_vpn = walk_vpn;
    end
    ef = have && cyc == fill_at;
    chk("fill_en", 64'(fill_en), 64'(ef));
    if (ef) begin
      chk("fill_way", 64'(fill_way), 64'(victim));
      chk("fill_vpn", 64'(fill_vpn), 64'(t_va[VA_W-1:PG_OFF]));
      chk("fill_pcid", 64'(fill_pcid), 64'(t_pc));
      chk("fill_ppn", 64'(fill_ppn), 64'(t_ppn));
      fill_q.push_back(int'(fill_way));
      obs_fill_vpn = fill_vpn; obs_fill_ppn = fill_ppn;
    end
    erv = have && cyc == resp_at;
    chk("resp_valid", 64'(resp_valid), 64'(erv));
    if (erv) begin
      chk("resp_id", 64'(resp_id), 64'(t_id));
      chk("resp_paddr", resp_paddr, t_pa);
      chk("resp_fault", 64'(resp_fault), 64'(t_fault));
      obs_resp_cyc = cyc; obs_resp_pa = resp_paddr;
      obs_resp_id = resp_id; obs_resp_fault = resp_fault;
    end
  endtask

  task automatic model_update();
    logic g;
    int rdy, lat;
    if (have && cyc == fill_at) victim = (victim + 1) % WAYS;
    if (!busy() && req_valid != 2'b00) begin
      g = (req_valid == 2'b11) ? ptr : (req_valid == 2'b10);
      if (req_valid == 2'b11) ptr = ~ptr;
      hs_count++;
      have = 1'b1; hs = cyc; t_id = g;
      t_va = g ? req_vaddr1 : req_vaddr0;
      t_pc = g ? req_pcid1 : req_pcid0;
      if (dir_en) begin
        t_hit = dir_hit; t_vec = dir_vec; t_lkpa = dir_paddr; rdy = dir_rdy; lat = dir_lat;
        t_ppn = dir_ppn; t_fault = dir_fault;
      end else begin
        t_hit = 1'($urandom); t_vec = 8'($urandom_range(1, 255)); t_lkpa = {$urandom, $urandom};
        rdy = $urandom_range(0, 3); lat = $urandom_range(1, 5);
        t_ppn = 52'({$urandom, $urandom}); t_fault = ($urandom_range(0, 4) == 0);
      end
      if (t_hit) begin
        t_fault = 1'b0; t_pa = t_lkpa;
        rdy_at = -1; done_at = -1; fill_at = -1; resp_at = hs + 3;
      end else begin
        rdy_at = hs + 3 + rdy; done_at = rdy_at + lat;
        if (t_fault) begin
          fill_at = -1; resp_at = done_at + 1; t_pa = '0;
        end else begin
          fill_at = done_at + 1; resp_at = done_at + 2; t_pa = {t_ppn, t_va[PG_OFF-1:0]};
        end
      end
      if (txn_left > 0) begin
        txn_left--;
        if (txn_left == 0) vmode = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    check();
    model_update();
    cyc++;
  endtask

  task automatic run(input int n, input int budget);
    int start, b;
    logic pending;
    start = hs_count; b = 0; txn_left = n;
    pending = 1'b1;
    while (pending && b < budget) begin
      cycle();
      b++;
      pending = (hs_count - start < n) || (have && cyc <= resp_at);
    end
    chk("run_budget", 64'(pending), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_id"}, 64'(resp_id), 64'd0);
    chk({tag, "_resp_paddr"}, resp_paddr, 64'd0);
    chk({tag, "_resp_fault"}, 64'(resp_fault), 64'd0);
    chk({tag, "_lk_addr"}, lk_addr, 64'd0);
    chk({tag, "_lk_pcid"}, 64'(lk_pcid), 64'd0);
    chk({tag, "_walk_valid"}, 64'(walk_valid), 64'd0);
    chk({tag, "_walk_vpn"}, 64'(walk_vpn), 64'd0);
    chk({tag, "_fill_en"}, 64'(fill_en), 64'd0);
    chk({tag, "_fill_way"}, 64'(fill_way), 64'd0);
    chk({tag, "_fill_ppn"}, 64'(fill_ppn), 64'd0);
  endtask

  initial begin
    int exp_w[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int exp_g[4] = '{0, 1, 0, 1};
    int b;
    req_valid = '0; req_vaddr0 = '0; req_vaddr1 = '0; req_pcid0 = '0; req_pcid1 = '0;
    lk_paddr = '0; lk_hit = '0; walk_ready = 1'b0; walk_done = 1'b0; walk_ppn = '0; walk_fault = 1'b0;
    #1 rst = 1'b1;
    #2 chk_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    // hit on port 0
    fix_addr = 1'b1; fx_va0 = '1; fx_pc0 = '0; fx_va1 = 64'h2000; fx_pc1 = 12'h7;
    dir_en = 1'b1; dir_hit = 1'b1; dir_vec = 8'h80; dir_paddr = 64'h1234; dir_fault = 1'b0;
    dir_rdy = 0; dir_lat = 1; dir_ppn = '0;
    obs_walk_cnt = 0; fill_q.delete();
    vmode = 1; run(1, 50);
    chk("hit_paddr", obs_resp_pa, 64'h1234);
    chk("hit_id", 64'(obs_resp_id), 64'd0);
    chk("hit_latency", 64'(obs_resp_cyc - obs_hs_cyc), 64'd3);
    chk("hit_no_walk", 64'(obs_walk_cnt), 64'd0);
    chk("hit_no_fill", 64'(fill_q.size()), 64'd0);

    // miss with fill on port 1
    fx_va1 = 64'h0000_0000_0040_0abc; fx_pc1 = 12'h5;
    dir_hit = 1'b0; dir_rdy = 2; dir_lat = 5; dir_ppn = 52'h77;
    vmode = 2; run(1, 100);
    chk("miss_walk_vpn", 64'(obs_walk_vpn), 64'h400);
    chk("miss_fill_cnt", 64'(fill_q.size()), 64'd1);
    chk("miss_fill_way", 64'(fill_q[0]), 64'd0);
    chk("miss_fill_vpn", 64'(obs_fill_vpn), 64'h400);
    chk("miss_fill_ppn", 64'(obs_fill_ppn), 64'h77);
    chk("miss_paddr", obs_resp_pa, 64'h77abc);
    chk("miss_id", 64'(obs_resp_id), 64'd1);
    chk("miss_latency", 64'(obs_resp_cyc - obs_hs_cyc), 64'd12);

    // both ports held valid over 4 hits (multi-hot hit vector)
    fx_va0 = 64'h1000; fx_va1 = 64'h2000;
    dir_hit = 1'b1; dir_vec = 8'h03; dir_paddr = 64'habc000;
    grant_q.delete();
    vmode = 3; run(4, 100);
    chk("arb_count", 64'(grant_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("arb_grant", 64'(grant_q[i]), 64'(exp_g[i]));

    // walk fault, then a clean miss fills the way still pending
    dir_hit = 1'b0; dir_fault = 1'b1; dir_rdy = 0; dir_lat = 1;
    fill_q.delete();
    vmode = 1; run(1, 50);
    chk("fault_no_fill", 64'(fill_q.size()), 64'd0);
    chk("fault_flag", 64'(obs_resp_fault), 64'd1);
    chk("fault_paddr", obs_resp_pa, 64'd0);
    dir_fault = 1'b0;
    vmode = 1; run(1, 50);
    chk("post_fault_way", 64'(fill_q[0]), 64'd1);

    // async reset while waiting for the walk, then a stray walk_done
    dir_rdy = 0; dir_lat = 30;
    vmode = 1; txn_left = 1; b = 0;
    while (!(have && cyc > rdy_at + 2) && b < 40) begin cycle(); b++; end
    chk("reach_walk_wait", 64'(have && cyc > rdy_at + 2), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    have = 1'b0; ptr = 1'b0; victim = 0; vmode = 0; txn_left = 0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    force_done = 1'b1; cycle(); force_done = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // 9 clean misses wrap the victim way
    fix_addr = 1'b0; dir_rdy = 1; dir_lat = 2; dir_ppn = 52'h3_c0de;
    fill_q.delete();
    vmode = 4; run(9, 400);
    chk("wrap_count", 64'(fill_q.size()), 64'd9);
    for (int i = 0; i < 9; i++) chk("wrap_way", 64'(fill_q[i]), 64'(exp_w[i]));

    // randomized traffic
    dir_en = 1'b0;
    vmode = 4; run(300, 20000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
